control_unit_fft_iter_cfg: RTL and testbench
============================================

Name: control_unit_fft_iter_cfg

Overview:
Parametrised successor of the fixed-size iterative-FFT sequencer. Sequences read / pipeline-wait / write butterfly cycles over a runtime-selectable transform size (2^LOG2N points) with a parameterised read-path latency. Adds a DONE pulse, an ABORT input, config-error reporting and exported layer/butterfly indices. Sits between the FFT top-level and the address generator, butterfly datapath and dual-port data RAM.

Parameters:
LAYERS, 10, maximum supported log2(N); LOG2N may select 1..LAYERS
LayWL, 4, width of layer index/LOG2N; must satisfy 2^LayWL > LAYERS
ButtWL, 9, width of butterfly index; must satisfy 2^ButtWL >= 2^(LAYERS-1)
RD_LAT, 1, wait cycles between read strobe and write (0..7)
DlyWL, 3, width of wait counter; must satisfy 2^DlyWL > RD_LAT

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
EN  in  1  global enable; when 0 every register holds its value
START  in  1  start request, sampled in IDLE only
ABORT  in  1  return to IDLE on the next enabled edge
LOG2N  in  LayWL  transform size select, latched on accepted START
BUSY  out  1  high whenever state != IDLE
BUT_STROB  out  1  high in READ
RAM_EN_R  out  1  high in READ
RAM_EN_WR  out  1  high in WRITE
Wr  out  1  high in WRITE
ADDR_EN  out  1  high in WRITE
ADDR_RST  out  1  high in IDLE
LAY_EN  out  1  one-cycle pulse in the WRITE of the last butterfly of every layer except the final one
LAST_LAY  out  1  high while LAY_IDX == latched LOG2N-1 and BUSY
DONE  out  1  registered one-cycle pulse after the final WRITE
CFG_ERR  out  1  registered one-cycle pulse when START carries an illegal LOG2N
BUT_IDX  out  ButtWL  current butterfly index within the layer
LAY_IDX  out  LayWL  current layer index

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE; BUT_IDX=0, LAY_IDX=0, wait counter=0, latched size=0, DONE=0, CFG_ERR=0. Consequently BUSY=0, ADDR_RST=1, all other strobes 0, LAST_LAY=0.
- EN=0 freezes the state, counters, latched size, DONE and CFG_ERR. Strobes are decoded combinationally from the frozen state and stay as they are.
- States: IDLE, READ, WAIT, WRITE.
- IDLE:
  - START=1 with 1<=LOG2N<=LAYERS: latch LOG2N (L), clear indices, go to READ.
  - START=1 with an illegal LOG2N: stay in IDLE and pulse CFG_ERR for one cycle.
- READ (1 cycle): go to WAIT if RD_LAT>0, otherwise go directly to WRITE. Load the wait counter with RD_LAT-1.
- WAIT (RD_LAT cycles): decrement the wait counter; go to WRITE when it reaches 0.
- WRITE (1 cycle): NB = 2^(L-1).
  - BUT_IDX < NB-1: BUT_IDX+1, go to READ.
  - BUT_IDX == NB-1 and LAY_IDX < L-1: BUT_IDX=0, LAY_IDX+1, LAY_EN=1, go to READ.
  - BUT_IDX == NB-1 and LAY_IDX == L-1: go to IDLE; DONE=1 on the following cycle; indices clear to 0.
- BUSY duration per transform: L * NB * (RD_LAT+2) cycles, excluding cycles where EN=0.
- ABORT=1 in any non-IDLE state: go to IDLE, clear indices, no DONE. ABORT has priority over all transitions. In IDLE, ABORT is ignored.
- START while BUSY is ignored. START and ABORT together in IDLE: START is accepted.
- L=1 (NB=1): a single butterfly. LAST_LAY is high for the whole run and LAY_EN never pulses.
- Index arithmetic is unsigned. Indices never wrap, because the terminal compares use the latched L.
- The LOG2N input may change while BUSY without effect.

Test Plan:
- RD_LAT=1, LOG2N=3, START pulse -> BUSY high exactly 36 cycles; 12 READ and 12 WRITE strobes; LAY_EN pulses at the 4th and 8th WRITE; LAST_LAY high from the 9th READ; DONE pulse 1 cycle after the 12th WRITE.
- RD_LAT=0 build, LOG2N=1 -> READ, WRITE, IDLE: BUSY 2 cycles, LAY_EN never asserted, LAST_LAY high both cycles, DONE follows.
- LOG2N=0 and LOG2N=LAYERS+1 with START -> CFG_ERR 1-cycle pulse each time, BUSY stays 0. Then LOG2N=LAYERS -> runs LAYERS*2^(LAYERS-1)*(RD_LAT+2) cycles.
- ABORT asserted in WAIT of layer 1, butterfly 2 -> IDLE next cycle, indices 0, no DONE. A new START runs a full transform correctly.
- EN held low for 5 cycles mid-run, then START pulsed while BUSY -> state and indices frozen during the stall, total run extended by 5 cycles, the extra START has no effect.
- RST asserted asynchronously mid-WRITE -> outputs take reset values before the next CLK edge; run does not resume after RST releases.

Source files
------------

// File: rtl/control_unit_fft_iter_cfg_if.sv
// Bundle of control, status and index signals exchanged between the FFT
// top-level and the iterative-FFT sequencer. The slave side is the sequencer.
// STATE_DBG mirrors the sequencer state register for observation.
interface control_unit_fft_iter_cfg_if #(
  parameter int LayWL  = 4,
  parameter int ButtWL = 9
);
  logic              EN;
  logic              START;
  logic              ABORT;
  logic [LayWL-1:0]  LOG2N;
  logic              BUSY;
  logic              BUT_STROB;
  logic              RAM_EN_R;
  logic              RAM_EN_WR;
  logic              Wr;
  logic              ADDR_EN;
  logic              ADDR_RST;
  logic              LAY_EN;
  logic              LAST_LAY;
  logic              DONE;
  logic              CFG_ERR;
  logic [ButtWL-1:0] BUT_IDX;
  logic [LayWL-1:0]  LAY_IDX;
  logic [1:0]        STATE_DBG;

  // Request/response contract: START is a level sampled only while the
  // sequencer is idle (BUSY=0); it is accepted on that enabled edge and BUSY
  // rises after it. ABORT is sampled on every enabled edge while BUSY=1.
  // DONE and CFG_ERR are single-cycle registered responses.
  modport master (
    output EN, START, ABORT, LOG2N,
    input  BUSY, BUT_STROB, RAM_EN_R, RAM_EN_WR, Wr, ADDR_EN, ADDR_RST,
    input  LAY_EN, LAST_LAY, DONE, CFG_ERR, BUT_IDX, LAY_IDX, STATE_DBG
  );

  modport slave (
    input  EN, START, ABORT, LOG2N,
    output BUSY, BUT_STROB, RAM_EN_R, RAM_EN_WR, Wr, ADDR_EN, ADDR_RST,
    output LAY_EN, LAST_LAY, DONE, CFG_ERR, BUT_IDX, LAY_IDX, STATE_DBG
  );
endinterface

// File: rtl/control_unit_fft_iter_cfg.sv
// Iterative-FFT sequencer with runtime transform size. Steps through
// READ / WAIT(RD_LAT cycles) / WRITE for every butterfly of every layer of a
// 2^L-point transform, exporting layer/butterfly indices and RAM/address
// strobes. Supports abort, a completion pulse and illegal-size reporting.
module control_unit_fft_iter_cfg #(
  parameter int LAYERS = 10,
  parameter int LayWL  = 4,
  parameter int ButtWL = 9,
  parameter int RD_LAT = 1,
  parameter int DlyWL  = 3
) (
  input logic CLK,
  input logic RST,
  control_unit_fft_iter_cfg_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  localparam logic [LayWL-1:0] MAX_L     = LayWL'(LAYERS);
  localparam logic [DlyWL-1:0] WAIT_INIT = (RD_LAT > 0) ? DlyWL'(RD_LAT - 1) : '0;
  localparam bit               HAS_WAIT  = (RD_LAT > 0);

  state_t            state_q, state_d;
  logic [ButtWL-1:0] but_q, but_d;
  logic [LayWL-1:0]  lay_q, lay_d;
  logic [LayWL-1:0]  l_q, l_d;
  logic [DlyWL-1:0]  wait_q, wait_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;

  // Terminal values derived from the latched size, so indices never wrap.
  // When idle l_q may be 0; these compares are only consumed while busy.
  logic [LayWL-1:0]  l_m1;
  logic [ButtWL:0]   nb_full;
  logic [ButtWL-1:0] nb_m1;
  logic              last_but;
  logic              last_lay;
  logic              size_ok;

  assign l_m1     = l_q - LayWL'(1);
  assign nb_full  = (ButtWL + 1)'(1) << l_m1;
  assign nb_m1    = ButtWL'(nb_full - (ButtWL + 1)'(1));
  assign last_but = (but_q == nb_m1);
  assign last_lay = (lay_q == l_m1);
  assign size_ok  = (bus.LOG2N != '0) && (bus.LOG2N <= MAX_L);

  // State and counter registers; EN=0 freezes everything.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      but_q     <= '0;
      lay_q     <= '0;
      l_q       <= '0;
      wait_q    <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else if (bus.EN) begin
      state_q   <= state_d;
      but_q     <= but_d;
      lay_q     <= lay_d;
      l_q       <= l_d;
      wait_q    <= wait_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state logic: ABORT wins over every transition out of a busy state.
  always_comb begin
    state_d   = state_q;
    but_d     = but_q;
    lay_d     = lay_q;
    l_d       = l_q;
    wait_d    = wait_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    if (state_q != S_IDLE && bus.ABORT) begin
      state_d = S_IDLE;
      but_d   = '0;
      lay_d   = '0;
      wait_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.START) begin
            if (size_ok) begin
              l_d     = bus.LOG2N;
              but_d   = '0;
              lay_d   = '0;
              state_d = S_READ;
            end else begin
              cfg_err_d = 1'b1;
            end
          end
        end
        S_READ: begin
          wait_d  = WAIT_INIT;
          state_d = HAS_WAIT ? S_WAIT : S_WRITE;
        end
        S_WAIT: begin
          if (wait_q == '0) state_d = S_WRITE;
          else              wait_d  = wait_q - DlyWL'(1);
        end
        S_WRITE: begin
          if (!last_but) begin
            but_d   = but_q + ButtWL'(1);
            state_d = S_READ;
          end else if (!last_lay) begin
            but_d   = '0;
            lay_d   = lay_q + LayWL'(1);
            state_d = S_READ;
          end else begin
            but_d   = '0;
            lay_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Strobes decoded from the registered state only.
  assign bus.BUSY      = (state_q != S_IDLE);
  assign bus.BUT_STROB = (state_q == S_READ);
  assign bus.RAM_EN_R  = (state_q == S_READ);
  assign bus.RAM_EN_WR = (state_q == S_WRITE);
  assign bus.Wr        = (state_q == S_WRITE);
  assign bus.ADDR_EN   = (state_q == S_WRITE);
  assign bus.ADDR_RST  = (state_q == S_IDLE);
  assign bus.LAY_EN    = (state_q == S_WRITE) && last_but && !last_lay;
  assign bus.LAST_LAY  = (state_q != S_IDLE) && last_lay;
  assign bus.DONE      = done_q;
  assign bus.CFG_ERR   = cfg_err_q;
  assign bus.BUT_IDX   = but_q;
  assign bus.LAY_IDX   = lay_q;
  assign bus.STATE_DBG = state_q;

endmodule

// File: tb/tb_control_unit_fft_iter_cfg.sv
// Bench for the configurable iterative-FFT sequencer. Main instance uses the
// default build (LAYERS=10, RD_LAT=1); a second small instance has RD_LAT=0.
module tb_control_unit_fft_iter_cfg;

  localparam int LAYERS = 10;
  localparam int LayWL  = 4;
  localparam int ButtWL = 9;
  localparam int RD_LAT = 1;
  localparam int DlyWL  = 3;
  localparam int P      = RD_LAT + 2;
  localparam int EW     = ButtWL + LayWL + 2;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  control_unit_fft_iter_cfg_if #(.LayWL(LayWL), .ButtWL(ButtWL)) bus ();
  control_unit_fft_iter_cfg_if #(.LayWL(2), .ButtWL(2)) bus0 ();

  control_unit_fft_iter_cfg #(
    .LAYERS(LAYERS), .LayWL(LayWL), .ButtWL(ButtWL), .RD_LAT(RD_LAT), .DlyWL(DlyWL)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  control_unit_fft_iter_cfg #(
    .LAYERS(3), .LayWL(2), .ButtWL(2), .RD_LAT(0), .DlyWL(1)
  ) dut0 (
    .CLK(CLK), .RST(RST), .bus(bus0)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  int rd_cnt      = 0;
  logic [EW-1:0] exp_q[$];   // {LAY_EN, LAST_LAY, LAY_IDX, BUT_IDX} per butterfly

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every enabled READ peeks and every enabled WRITE pops the queue.
  always @(negedge CLK) begin
    if (RST && bus.EN) begin
      if (bus.BUT_STROB) begin
        rd_cnt++;
        chk("rd_queue_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0)
          chk("rd_idx", {bus.LAST_LAY, bus.LAY_IDX, bus.BUT_IDX}, 32'(exp_q[0][EW-2:0]));
      end
      if (bus.Wr) begin
        chk("wr_queue_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0)
          chk("wr_idx", {bus.LAY_EN, bus.LAST_LAY, bus.LAY_IDX, bus.BUT_IDX}, 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cfg_err_probe(input int l);
    bus.START = 1'b1;
    bus.LOG2N = LayWL'(l);
    @(posedge CLK); #1;
    bus.START = 1'b0;
    chk("cfg_err_pulse", bus.CFG_ERR, 1);
    chk("cfg_err_busy", bus.BUSY, 0);
    @(posedge CLK); #1;
    chk("cfg_err_clear", bus.CFG_ERR, 0);
    chk("cfg_err_idle", bus.BUSY, 0);
  endtask

  // One transform of size 2^l on the main instance, checked cycle by cycle.
  // stall_at/abort_at/rst_at are busy-cycle numbers (0 = not used).
  task automatic run(input int l, input int stall_at, input int abort_at,
                     input int rst_at, input bit with_abort);
    int nb, total, cnt, stall_cnt, stall_left, idx, ph, lay, but, rd0, exp_busy;
    bit en_prev, rd, wr, le, ll;
    nb = 1 << (l - 1);
    total = l * nb * P;
    cnt = 0; stall_cnt = 0; stall_left = 5;
    for (int a = 0; a < l; a++)
      for (int b = 0; b < nb; b++)
        exp_q.push_back({1'((b == nb - 1) && (a < l - 1)), 1'(a == l - 1), LayWL'(a), ButtWL'(b)});
    rd0 = rd_cnt;
    bus.START = 1'b1;
    bus.ABORT = with_abort;
    bus.LOG2N = LayWL'(l);
    @(posedge CLK); #1;
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    bus.LOG2N = LayWL'($urandom_range(0, 15));
    en_prev = 1'b1;
    forever begin
      if (en_prev) cnt++; else stall_cnt++;
      if (bus.BUSY !== 1'b1 || cnt > total + 2) break;
      idx = (cnt - 1) / P;
      ph  = (cnt - 1) % P;
      lay = idx / nb;
      but = idx % nb;
      rd  = (ph == 0);
      wr  = (ph == P - 1);
      le  = wr && (but == nb - 1) && (lay < l - 1);
      ll  = (lay == l - 1);
      chk("but_idx", bus.BUT_IDX, but);
      chk("lay_idx", bus.LAY_IDX, lay);
      chk("strobes", {bus.BUSY, bus.BUT_STROB, bus.RAM_EN_R, bus.RAM_EN_WR, bus.Wr,
                      bus.ADDR_EN, bus.ADDR_RST, bus.LAY_EN, bus.LAST_LAY},
                     {1'b1, rd, rd, wr, wr, wr, 1'b0, le, ll});
      chk("done_low_busy", bus.DONE, 0);
      if (rst_at > 0 && cnt == rst_at) begin
        #2; RST = 1'b0; #1;
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_addr_rst", bus.ADDR_RST, 1);
        chk("rst_wr", bus.Wr, 0);
        chk("rst_idx", {bus.LAY_IDX, bus.BUT_IDX}, 0);
        chk("rst_last_lay", bus.LAST_LAY, 0);
        exp_q.delete();
        @(posedge CLK); #1;
        RST = 1'b1;
        repeat (4) begin
          @(posedge CLK); #1;
          chk("rst_no_resume", bus.BUSY, 0);
        end
        return;
      end
      bus.EN    = 1'b1;
      bus.START = 1'b0;
      bus.ABORT = 1'b0;
      if (stall_at > 0 && cnt == stall_at && stall_left > 0) begin
        bus.EN = 1'b0;
        stall_left--;
      end
      if (stall_at > 0 && cnt == stall_at + 1) begin
        bus.START = 1'b1;
        bus.LOG2N = LayWL'(2);
      end
      if (abort_at > 0 && cnt == abort_at) bus.ABORT = 1'b1;
      en_prev = bus.EN;
      @(posedge CLK); #1;
    end
    bus.EN = 1'b1; bus.START = 1'b0; bus.ABORT = 1'b0;
    exp_busy = (abort_at > 0) ? abort_at : total;
    chk("busy_cycles", cnt - 1, exp_busy);
    chk("stall_cycles", stall_cnt, (stall_at > 0) ? 5 : 0);
    chk("done_pulse", bus.DONE, (abort_at > 0) ? 0 : 1);
    chk("idle_idx", {bus.LAY_IDX, bus.BUT_IDX}, 0);
    chk("idle_addr_rst", bus.ADDR_RST, 1);
    if (abort_at == 0) begin
      chk("queue_drained", exp_q.size(), 0);
      chk("read_count", rd_cnt - rd0, l * nb);
    end
    exp_q.delete();
    @(posedge CLK); #1;
    chk("done_clear", bus.DONE, 0);
    chk("stay_idle", bus.BUSY, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c0;
    bus.EN = 1'b1;  bus.START = 1'b0;  bus.ABORT = 1'b0;  bus.LOG2N = '0;
    bus0.EN = 1'b1; bus0.START = 1'b0; bus0.ABORT = 1'b0; bus0.LOG2N = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_strobes", {bus.BUSY, bus.BUT_STROB, bus.RAM_EN_R, bus.RAM_EN_WR, bus.Wr,
                          bus.ADDR_EN, bus.ADDR_RST, bus.LAY_EN, bus.LAST_LAY},
                         9'b000000100);
    chk("reset_done_err", {bus.DONE, bus.CFG_ERR}, 0);
    chk("reset_idx", {bus.LAY_IDX, bus.BUT_IDX}, 0);
    chk("reset0_busy", bus0.BUSY, 0);
    RST = 1'b1;
    @(posedge CLK); #1;

    cfg_err_probe(0);
    cfg_err_probe(LAYERS + 1);
    cfg_err_probe(15);

    run(3, 0, 0, 0, 1'b0);        // 36 busy cycles, LAY_EN at writes 4 and 8
    run(1, 0, 0, 0, 1'b0);        // single butterfly
    run(3, 0, 20, 0, 1'b0);       // abort in WAIT of layer 1, butterfly 2
    run(3, 0, 0, 0, 1'b0);        // clean run after abort
    run(3, 7, 0, 0, 1'b0);        // 5-cycle stall, then ignored START
    run(2, 0, 0, 0, 1'b1);        // START with ABORT in IDLE is accepted
    run(3, 0, 0, 12, 1'b0);       // async reset in a WRITE
    run(3, 0, 0, 0, 1'b0);
    run(LAYERS, 0, 0, 0, 1'b0);   // largest size

    // RD_LAT=0 instance: L=1 -> READ, WRITE, IDLE
    bus0.START = 1'b1; bus0.LOG2N = 2'd1;
    @(posedge CLK); #1;
    bus0.START = 1'b0;
    chk("l1_read", {bus0.BUSY, bus0.BUT_STROB, bus0.Wr, bus0.LAY_EN, bus0.LAST_LAY}, 5'b11001);
    @(posedge CLK); #1;
    chk("l1_write", {bus0.BUSY, bus0.BUT_STROB, bus0.Wr, bus0.LAY_EN, bus0.LAST_LAY}, 5'b10101);
    @(posedge CLK); #1;
    chk("l1_done", {bus0.BUSY, bus0.DONE}, 2'b01);
    @(posedge CLK); #1;
    chk("l1_done_clear", bus0.DONE, 0);

    // RD_LAT=0 instance: L=2 -> 2*2*2 busy cycles
    bus0.START = 1'b1; bus0.LOG2N = 2'd2;
    @(posedge CLK); #1;
    bus0.START = 1'b0;
    c0 = 0;
    while (bus0.BUSY === 1'b1 && c0 < 50) begin
      c0++;
      @(posedge CLK); #1;
    end
    chk("l2_busy_cycles", c0, 8);
    chk("l2_done", bus0.DONE, 1);

    // RD_LAT=0 instance: illegal size 0
    bus0.START = 1'b1; bus0.LOG2N = 2'd0;
    @(posedge CLK); #1;
    bus0.START = 1'b0;
    chk("inst0_cfg_err", {bus0.CFG_ERR, bus0.BUSY}, 2'b10);
    @(posedge CLK); #1;
    chk("inst0_cfg_err_clear", bus0.CFG_ERR, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
